// File: rtl/switch_cond_pkg.sv
// Shared constants for the switch conditioner: channel FSM state encoding and
// the default debounce window for a 50 MHz clock.
package switch_cond_pkg;

    localparam logic [1:0] S_LO = 2'd0;
    localparam logic [1:0] W_HI = 2'd1;
    localparam logic [1:0] S_HI = 2'd2;
    localparam logic [1:0] W_LO = 2'd3;

    // 20 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: input synchroniser, 4-state debounce FSM with a stability
// counter, a registered debounced level and a one-cycle rising-edge strobe.
module debounce_ch
    import switch_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       raw_i,
    output logic       level_o,
    output logic       rise_o,
    output logic [1:0] state_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;

    // Synchroniser chain bringing the asynchronous pin into the clock domain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Debounce FSM: a level is accepted only after an unbroken stable window
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        case (state_q)
            S_LO: begin
                if (sync_s) begin
                    state_d = W_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            W_HI: begin
                if (!sync_s) begin
                    state_d = S_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_HI: begin
                if (!sync_s) begin
                    state_d = W_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            W_LO: begin
                if (sync_s) begin
                    state_d = S_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LO;
                    level_d = 1'b0;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LO;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_LO;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign state_o = state_q;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the raw SW and Mode pins into debounced levels plus an SW press strobe.
// Define SWITCH_AUTOREPEAT_EN to add hold-to-repeat strobes on the SW channel.
module switch_conditioner
    import switch_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
`ifdef SWITCH_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic clk_50M,
    input  logic Reset,
    input  logic SW_raw,
    input  logic Mode_raw,
    output logic SW,
    output logic SW_pulse,
    output logic Mode
);

    logic       sw_level_s;
    logic       sw_rise_s;
    logic       mode_level_s;
    logic       mode_rise_unused_s;
    logic [1:0] mode_state_unused_s;
`ifdef SWITCH_AUTOREPEAT_EN
    logic [1:0] sw_state_s;
`else
    logic [1:0] sw_state_unused_s;
`endif

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sw_ch (
        .clk_i   (clk_50M),
        .rst_ni  (Reset),
        .raw_i   (SW_raw),
        .level_o (sw_level_s),
        .rise_o  (sw_rise_s),
`ifdef SWITCH_AUTOREPEAT_EN
        .state_o (sw_state_s)
`else
        .state_o (sw_state_unused_s)
`endif
    );

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_mode_ch (
        .clk_i   (clk_50M),
        .rst_ni  (Reset),
        .raw_i   (Mode_raw),
        .level_o (mode_level_s),
        .rise_o  (mode_rise_unused_s),
        .state_o (mode_state_unused_s)
    );

    assign SW   = sw_level_s;
    assign Mode = mode_level_s;

`ifdef SWITCH_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE    = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              repeat_phase_q, repeat_phase_d;
    logic              rep_pulse_q, rep_pulse_d;

    // Hold timer: first repeat after the initial delay, then one per period; cleared outside S_HI
    always_comb begin
        hold_d         = hold_q;
        repeat_phase_d = repeat_phase_q;
        rep_pulse_d    = 1'b0;
        if (sw_state_s != S_HI) begin
            hold_d         = HOLD_ZERO;
            repeat_phase_d = 1'b0;
        end else if (!repeat_phase_q && (hold_q == DELAY_LAST)) begin
            hold_d         = HOLD_ZERO;
            repeat_phase_d = 1'b1;
            rep_pulse_d    = 1'b1;
        end else if (repeat_phase_q && (hold_q == PERIOD_LAST)) begin
            hold_d         = HOLD_ZERO;
            rep_pulse_d    = 1'b1;
        end else begin
            hold_d         = hold_q + HOLD_ONE;
        end
    end

    // Repeat timer registers
    always_ff @(posedge clk_50M or negedge Reset) begin
        if (!Reset) begin
            hold_q         <= HOLD_ZERO;
            repeat_phase_q <= 1'b0;
            rep_pulse_q    <= 1'b0;
        end else begin
            hold_q         <= hold_d;
            repeat_phase_q <= repeat_phase_d;
            rep_pulse_q    <= rep_pulse_d;
        end
    end

    // Both sources are flops and can never be high together
    assign SW_pulse = sw_rise_s | rep_pulse_q;
`else
    assign SW_pulse = sw_rise_s;
`endif

endmodule
